// File: rtl/cmd_pkg.sv
// +----------------------------------------------------------------------------
// | cmd_pkg : opcodes, sequencer states and instruction-word layout
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

package cmd_pkg;

  localparam int OP_W = 8;

  // Instruction word: opcode sits directly above the count field
  localparam int CNT_LSB = 0;

  localparam logic [OP_W-1:0] LOAD_R   = 8'h01;
  localparam logic [OP_W-1:0] LOAD_L   = 8'h02;
  localparam logic [OP_W-1:0] LOAD_RL  = 8'h03;
  localparam logic [OP_W-1:0] CONV_R   = 8'h11;
  localparam logic [OP_W-1:0] CONV_L   = 8'h12;
  localparam logic [OP_W-1:0] CONV_RL  = 8'h13;
  localparam logic [OP_W-1:0] WRITE_R  = 8'h21;
  localparam logic [OP_W-1:0] WRITE_L  = 8'h22;
  localparam logic [OP_W-1:0] WRITE_RL = 8'h23;
  localparam logic [OP_W-1:0] PRINT_R  = 8'h41;
  localparam logic [OP_W-1:0] PRINT_L  = 8'h42;
  localparam logic [OP_W-1:0] PRINT_RL = 8'h43;
  localparam logic [OP_W-1:0] END      = 8'h80;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    FIN    = 3'd4
  } seq_state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    case (op)
      LOAD_R, LOAD_L, LOAD_RL,
      CONV_R, CONV_L, CONV_RL,
      WRITE_R, WRITE_L, WRITE_RL,
      PRINT_R, PRINT_L, PRINT_RL,
      END:     return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_sequencer_if.sv
// +----------------------------------------------------------------------------
// | cmd_sequencer_if : control, program-load and command bus of the sequencer
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

interface cmd_sequencer_if
  import cmd_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) ();

  logic                  start;
  logic                  abort;
  logic                  hold;
  logic                  prog_we;
  logic [ADDR_W-1:0]     prog_addr;
  logic [OP_W+CNT_W-1:0] prog_data;
  logic [OP_W-1:0]       Command;
  logic                  busy;
  logic                  done;
  logic [ADDR_W-1:0]     pc;
  logic                  err;

  modport master (
    output start, abort, hold, prog_we, prog_addr, prog_data,
    input  Command, busy, done, pc, err
  );

  modport slave (
    input  start, abort, hold, prog_we, prog_addr, prog_data,
    output Command, busy, done, pc, err
  );

endinterface

`default_nettype wire

// File: rtl/cmd_prog_mem.sv
// +----------------------------------------------------------------------------
// | cmd_prog_mem : register-array program store, sync write / sync read
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module cmd_prog_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  wire logic              clk,
  input  wire logic              we,
  input  wire logic [ADDR_W-1:0] waddr,
  input  wire logic [DATA_W-1:0] wdata,
  input  wire logic [ADDR_W-1:0] raddr,
  output logic      [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/cmd_sequencer.sv
// +----------------------------------------------------------------------------
// | cmd_sequencer : steps a stored {opcode, count} program onto Command
// | Optional illegal-opcode trap: CMD_SEQ_OPCHECK_EN.   Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int               ADDR_W   = 4,
  parameter int               CNT_W    = 8,
  parameter logic [OP_W-1:0]  IDLE_CMD = 8'h80
) (
  input  wire logic     clk,
  input  wire logic     reset,
  cmd_sequencer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  seq_state_t            r_state;
  logic [OP_W-1:0]       r_cmd;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_W-1:0]     r_pc;
  logic [CNT_W-1:0]      r_cnt;
  logic [OP_W+CNT_W-1:0] w_word;
  logic [OP_W-1:0]       w_op;
  logic [CNT_W-1:0]      w_count;

  cmd_prog_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (OP_W + CNT_W)
  ) u_mem (
    .clk   (clk),
    .we    (bus.prog_we && !r_busy),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (r_pc),
    .rdata (w_word)
  );

  assign w_op    = w_word[CNT_W +: OP_W];
  assign w_count = w_word[CNT_LSB +: CNT_W];

`ifdef CMD_SEQ_OPCHECK_EN
  logic r_err;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE && bus.start) begin
      r_err <= 1'b0;
    end else if (r_state == DECODE && !bus.abort && !bus.hold && !is_legal_op(w_op)) begin
      r_err <= 1'b1;
    end
  end
  assign bus.err = r_err;
`else
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cmd   <= IDLE_CMD;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pc    <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && bus.abort) begin
        r_state <= IDLE;
        r_cmd   <= IDLE_CMD;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_cmd <= IDLE_CMD;
            if (bus.start) begin
              r_pc    <= '0;
              r_busy  <= 1'b1;
              r_state <= FETCH;
            end
          end
          FETCH: begin
            if (!bus.hold) begin
              r_cmd   <= IDLE_CMD;
              r_state <= DECODE;
            end
          end
          DECODE: begin
            if (!bus.hold) begin
              if (w_op == END) begin
                r_cmd   <= IDLE_CMD;
                r_done  <= 1'b1;
                r_state <= FIN;
`ifdef CMD_SEQ_OPCHECK_EN
              end else if (!is_legal_op(w_op)) begin
                r_cmd   <= IDLE_CMD;
                r_busy  <= 1'b0;
                r_state <= IDLE;
`endif
              end else begin
                r_cmd   <= w_op;
                r_cnt   <= w_count;
                r_state <= EXEC;
              end
            end
          end
          EXEC: begin
            if (!bus.hold) begin
              if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
              end else if (r_pc != LAST_ADDR) begin
                r_pc    <= r_pc + ADDR_W'(1);
                r_cmd   <= IDLE_CMD;
                r_state <= FETCH;
              end else begin
                // Last word executed without an END: stop rather than wrap
                r_cmd   <= IDLE_CMD;
                r_done  <= 1'b1;
                r_state <= FIN;
              end
            end
          end
          FIN: begin
            r_cmd   <= IDLE_CMD;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: begin
            r_cmd   <= IDLE_CMD;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.Command = r_cmd;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pc      = r_pc;

endmodule

`default_nettype wire

// File: tb/tb_cmd_sequencer.sv
// +----------------------------------------------------------------------------
// | tb_cmd_sequencer : directed vectors and corner sequences for cmd_sequencer
// | Revision: 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_cmd_sequencer;

  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cmd_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  cmd_sequencer #(
    .ADDR_W   (ADDR_W),
    .CNT_W    (CNT_W),
    .IDLE_CMD (8'h80)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  typedef struct {
    logic       start;
    logic       abort;
    logic       hold;
    logic [7:0] cmd;
    logic       busy;
    logic       done;
    logic [3:0] pc;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; outputs are observed on the falling edge
  task automatic step();
    @(negedge clk);
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [7:0] op, input logic [7:0] c);
    bus.prog_we   = 1'b1;
    bus.prog_addr = a;
    bus.prog_data = {op, c};
    step();
    bus.prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_cmd(input logic [7:0] op, input int budget, output bit ok);
    int n = 0;
    while (bus.Command !== op && n < budget) begin
      step();
      n++;
    end
    ok = (bus.Command === op);
  endtask

  task automatic wait_done(input int budget, output int cyc);
    int base = done_cnt;
    cyc = 0;
    while (done_cnt == base && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    bit ok;
    int cyc, n, base, pc_at_done;
    logic [3:0] pc_hold;

    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0; bus.hold = 1'b0;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_cmd",  bus.Command, 8'h80);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pc",   bus.pc, 0);
    chk("rst_err",  bus.err, 0);

    // Basic program: {01,2} {11,0} {80}
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 4'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 4'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b0, 4'd2};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1, 4'd2};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 4'd2};

    write_word(4'd0, 8'h01, 8'd2);
    write_word(4'd1, 8'h11, 8'd0);
    write_word(4'd2, 8'h80, 8'd0);
    for (int i = 0; i < 12; i++) begin
      bus.start = vecs[i].start;
      bus.abort = vecs[i].abort;
      bus.hold  = vecs[i].hold;
      step();
      chk($sformatf("v%0d_cmd", i),  bus.Command, vecs[i].cmd);
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      chk($sformatf("v%0d_done", i), bus.done, vecs[i].done);
      chk($sformatf("v%0d_pc", i),   bus.pc, vecs[i].pc);
      chk($sformatf("v%0d_err", i),  bus.err, 0);
    end
    bus.start = 1'b0;

    // Sixteen PRINT_RL words, no END: must stop at pc 15
    for (int a = 0; a < 16; a++) write_word(a[3:0], 8'h43, 8'd0);
    base = done_cnt;
    pulse_start();
    n = 0; cyc = 0;
    while (done_cnt == base && cyc < 200) begin
      if (bus.Command === 8'h43) n++;
      step();
      cyc++;
    end
    pc_at_done = int'(bus.pc);
    chk("full_timeout", (cyc < 200), 1);
    chk("full_n43", n, 16);
    chk("full_pc_done", pc_at_done, 15);
    step();
    chk("full_busy_after", bus.busy, 0);
    chk("full_pc_nowrap", bus.pc, 15);
    chk("full_cmd_after", bus.Command, 8'h80);
    repeat (4) step();
    chk("full_done_once", done_cnt - base, 1);

    // Hold during EXEC of {21,5}
    write_word(4'd0, 8'h21, 8'd5);
    write_word(4'd1, 8'h80, 8'd0);
    pulse_start();
    wait_cmd(8'h21, 20, ok);
    chk("hold_found21", ok, 1);
    n = 0; pc_hold = 4'hf;
    while (bus.Command === 8'h21 && n < 50) begin
      n++;
      if (n == 5) pc_hold = bus.pc;
      bus.hold = (n >= 3 && n <= 6);
      step();
    end
    bus.hold = 1'b0;
    chk("hold_len", n, 10);
    chk("hold_pc", pc_hold, 0);
    wait_done(20, cyc);
    chk("hold_done", (cyc < 20), 1);
    step();

    // Abort during second instruction, then restart from pc 0
    write_word(4'd0, 8'h01, 8'd1);
    write_word(4'd1, 8'h11, 8'd3);
    write_word(4'd2, 8'h80, 8'd0);
    base = done_cnt;
    pulse_start();
    wait_cmd(8'h11, 30, ok);
    chk("abort_found11", ok, 1);
    step();
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk("abort_cmd", bus.Command, 8'h80);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    repeat (5) step();
    chk("abort_no_done", done_cnt - base, 0);
    chk("abort_idle_cmd", bus.Command, 8'h80);
    pulse_start();
    step(); step();
    chk("restart_cmd", bus.Command, 8'h01);
    chk("restart_pc", bus.pc, 0);
    wait_done(40, cyc);
    chk("restart_done", (cyc < 40), 1);
    step();

    // Writes and start while busy are dropped
    write_word(4'd0, 8'h02, 8'd3);
    write_word(4'd1, 8'h80, 8'd0);
    pulse_start();                  // observation 1
    step();                         // observation 2
    bus.start = 1'b1;
    write_word(4'd0, 8'h33, 8'd0);  // observation 3
    bus.start = 1'b0;
    chk("busy_cmd_obs3", bus.Command, 8'h02);
    wait_done(20, cyc);
    chk("busy_done_at", cyc + 3, 9);
    step();
    pulse_start();
    step(); step();
    chk("busy_mem_kept", bus.Command, 8'h02);
    wait_done(20, cyc);
    chk("busy_rerun_done", (cyc < 20), 1);
    step();

    // Illegal opcode {55,3}
    write_word(4'd0, 8'h55, 8'd3);
    write_word(4'd1, 8'h80, 8'd0);
    base = done_cnt;
    pulse_start();
    step(); step();
`ifdef CMD_SEQ_OPCHECK_EN
    chk("ill_cmd", bus.Command, 8'h80);
    chk("ill_err", bus.err, 1);
    chk("ill_busy", bus.busy, 0);
    repeat (4) step();
    chk("ill_no_done", done_cnt - base, 0);
    chk("ill_err_sticky", bus.err, 1);
    write_word(4'd0, 8'h01, 8'd0);
    pulse_start();
    chk("ill_err_clear", bus.err, 0);
    wait_done(20, cyc);
    chk("ill_rerun_done", (cyc < 20), 1);
`else
    n = 0;
    while (bus.Command === 8'h55 && n < 20) begin
      chk("ill_err_low", bus.err, 0);
      n++;
      step();
    end
    chk("ill_len", n, 4);
    wait_done(20, cyc);
    chk("ill_done", done_cnt - base, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Upstream stage of the R/L command decoder. Stores a small program of {opcode, repeat-count} words and issues each opcode on `Command` for a programmed number of cycles.
- Steps through LOAD/CONV/WRITE/PRINT phases automatically after a `start` pulse and stops on END (8'h80).
- Drives the decoder's 8-bit `Command` input directly; the decoder stays purely combinational.

Parameters:
- ADDR_W, 4, program-memory address width; depth = 2**ADDR_W words.
- CNT_W, 8, repeat-count field width; an instruction executes count+1 cycles.
- IDLE_CMD, 8'h80, opcode driven whenever no instruction is executing (END encoding).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins execution at address 0 when idle.
- abort  in  1  synchronous abort of a running program.
- hold  in  1  stall; freezes sequencer state while high.
- prog_we  in  1  program-memory write strobe.
- prog_addr  in  ADDR_W  program-memory write address.
- prog_data  in  8+CW  instruction word: [CNT_W+7:CNT_W] opcode, [CNT_W-1:0] count.
- Command  out  8  registered opcode to the decoder.
- busy  out  1  high from the cycle after an accepted start until return to IDLE.
- done  out  1  one-cycle pulse on normal completion.
- pc  out  ADDR_W  address of the current or last fetched instruction.
- err  out  1  illegal-opcode flag (see Optional Feature).

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values: Command=IDLE_CMD, busy=0, done=0, pc=0, err=0, state=IDLE, counter=0. Program memory contents are not cleared.
- Program memory: register array, synchronous write.
  - A write with prog_we=1 is accepted only when busy=0; writes while busy=1 are dropped.
  - Read is synchronous: the word at pc is valid one cycle after FETCH.
- States:
  - IDLE: Command=IDLE_CMD. On start=1, set pc←0 and go to FETCH; busy=1 from the next cycle.
  - FETCH: memory read at pc; Command=IDLE_CMD (one-cycle bubble between instructions). Next state is DECODE.
  - DECODE: latch the word.
    - If opcode==8'h80: go to FIN.
    - Otherwise: Command←opcode, counter←count, go to EXEC.
  - EXEC: Command holds the opcode.
    - counter>0: decrement it.
    - counter==0, pc≠2**ADDR_W−1: set pc←pc+1, go to FETCH, Command←IDLE_CMD.
    - counter==0, pc==2**ADDR_W−1: go to FIN (no wrap-around; implicit END).
  - FIN: Command=IDLE_CMD, done=1 for exactly this cycle, busy=0 from the next cycle, then IDLE.
- Timing: an instruction with count N holds Command for N+1 consecutive cycles. The first opcode appears 3 cycles after start is sampled (IDLE→FETCH→DECODE→EXEC registered).
- hold=1 in FETCH, DECODE or EXEC: state, pc, counter and Command all freeze. hold is ignored in IDLE and FIN.
- abort=1 in any state other than IDLE:
  - next cycle: state=IDLE, Command=IDLE_CMD, busy=0, no done pulse.
  - abort takes priority over hold.
- start while busy=1 is ignored. Simultaneous start and abort in IDLE: start wins. reset overrides everything.
- Command changes only at a clock edge, so the decoder outputs are glitch-free per cycle.

Optional Feature:
- Macro: CMD_SEQ_OPCHECK_EN.
- Defined: in DECODE, an opcode outside {01,02,03,11,12,13,21,22,23,41,42,43,80} sets err=1 (sticky until reset or next accepted start), and the sequencer goes to IDLE with no done pulse and Command=IDLE_CMD.
- Undefined: err is tied 0 and illegal opcodes are issued like any other opcode (the decoder treats them as END).

Decomposition:
- Shared package `cmd_pkg`:
  - opcode constants LOAD_R/L/RL, CONV_R/L/RL, WRITE_R/L/RL, PRINT_R/L/RL, END (8'h80);
  - state enum {IDLE, FETCH, DECODE, EXEC, FIN};
  - instruction-word field offsets.
- One sub-module: `cmd_prog_mem` (parameterised sync-write/sync-read register array). FSM and counter stay in `cmd_sequencer`.

Test Plan:
- Load {01,N=2},{11,N=0},{80}; pulse start → Command trace after start:
  - IDLE×2, 01×3, 80 (bubble), 80 (decode), 11×1, 80, 80;
  - done pulses once; busy low afterwards.
- Fill all 16 words with {43,N=0}, no END → 16 PRINT_RL pulses; pc stops at 15; done=1; no wrap to 0.
- During EXEC of {21,N=5}, assert hold for 4 cycles → Command stays 21 for 6+4 cycles; pc unchanged.
- Abort during the second instruction → next cycle Command=80, busy=0; no done pulse; a new start restarts from pc=0.
- prog_we to addr 0 while busy → memory unchanged (re-run shows original opcode). start while busy → no restart.
- With CMD_SEQ_OPCHECK_EN, word {55,N=3} → err=1, Command=80, no done. Without the macro → 55 held 4 cycles, err=0.
